// File: rtl/anim_pkg.sv
// Shared animation state codes, facing constants and output decode helpers.
// Imported by the sequencer and by the sprite renderer so codes stay in lockstep.
package anim_pkg;

  localparam logic [3:0] CS_IDLE       = 4'd0;
  localparam logic [3:0] CS_WALK       = 4'd1;
  localparam logic [3:0] CS_WALKBACK   = 4'd2;
  localparam logic [3:0] CS_ATT_START  = 4'd3;
  localparam logic [3:0] CS_ATT_END    = 4'd4;
  localparam logic [3:0] CS_ATT_PULL   = 4'd5;
  localparam logic [3:0] CS_BLOCK      = 4'd6;
  localparam logic [3:0] CS_GOTHIT     = 4'd7;
  localparam logic [3:0] CS_DATT_START = 4'd8;
  localparam logic [3:0] CS_DATT_PULL  = 4'd9;
  localparam logic [3:0] CS_DATT_END   = 4'd10;

  localparam bit FACE_RIGHT = 1'b1;
  localparam bit FACE_LEFT  = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE       = CS_IDLE,
    S_WALK       = CS_WALK,
    S_WALKBACK   = CS_WALKBACK,
    S_ATT_START  = CS_ATT_START,
    S_ATT_END    = CS_ATT_END,
    S_ATT_PULL   = CS_ATT_PULL,
    S_BLOCK      = CS_BLOCK,
    S_GOTHIT     = CS_GOTHIT,
    S_DATT_START = CS_DATT_START,
    S_DATT_PULL  = CS_DATT_PULL,
    S_DATT_END   = CS_DATT_END
  } anim_state_e;

  function automatic logic is_busy(input logic [3:0] s);
    return (s == CS_ATT_START) || (s == CS_ATT_END) || (s == CS_ATT_PULL) ||
           (s == CS_GOTHIT) || (s == CS_DATT_START) || (s == CS_DATT_PULL) ||
           (s == CS_DATT_END);
  endfunction

  function automatic logic is_hit_active(input logic [3:0] s);
    return (s == CS_ATT_END) || (s == CS_DATT_END);
  endfunction

endpackage

// File: rtl/sprite_anim_sequencer_if.sv
// Button/hit inputs and per-player animation outputs between game logic and renderer.
interface sprite_anim_if;
  logic       frame_tick;
  logic       btn_left, btn_right, btn_att, btn_datt, btn_blk;
  logic       btn2_left, btn2_right, btn2_att, btn2_datt, btn2_blk;
  logic       hit_in, hit2_in;
  logic [3:0] currentstate, currentstate2;
  logic       hit_active, hit_active2;
  logic       busy, busy2;

  modport master (
    output frame_tick,
    output btn_left, btn_right, btn_att, btn_datt, btn_blk,
    output btn2_left, btn2_right, btn2_att, btn2_datt, btn2_blk,
    output hit_in, hit2_in,
    input  currentstate, currentstate2, hit_active, hit_active2, busy, busy2
  );

  modport slave (
    input  frame_tick,
    input  btn_left, btn_right, btn_att, btn_datt, btn_blk,
    input  btn2_left, btn2_right, btn2_att, btn2_datt, btn2_blk,
    input  hit_in, hit2_in,
    output currentstate, currentstate2, hit_active, hit_active2, busy, busy2
  );
endinterface

// File: rtl/player_anim_fsm.sv
// One fighter's animation FSM: frame-aligned phase sequencing, hit/block handling.
// State and decoded flags update one cycle after a frame_tick and hold for the frame.
module player_anim_fsm
  import anim_pkg::*;
#(
  parameter int  T_START      = 4,
  parameter int  T_END        = 3,
  parameter int  T_PULL       = 4,
  parameter int  T_HIT        = 8,
  parameter bit  FACING_RIGHT = FACE_RIGHT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       att_i,
  input  logic       datt_i,
  input  logic       blk_i,
  input  logic       hit_i,
  output logic [3:0] state_o,
  output logic       hit_active_o,
  output logic       busy_o
);

  if (T_START < 1 || T_START > 15) begin : g_bad_t_start
    $error("T_START must be 1..15");
  end
  if (T_END < 1 || T_END > 15) begin : g_bad_t_end
    $error("T_END must be 1..15");
  end
  if (T_PULL < 1 || T_PULL > 15) begin : g_bad_t_pull
    $error("T_PULL must be 1..15");
  end
  if (T_HIT < 1 || T_HIT > 15) begin : g_bad_t_hit
    $error("T_HIT must be 1..15");
  end

  localparam logic [3:0] TS = 4'(T_START);
  localparam logic [3:0] TE = 4'(T_END);
  localparam logic [3:0] TP = 4'(T_PULL);
  localparam logic [3:0] TH = 4'(T_HIT);

  anim_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        hit_active_q, busy_q;
  logic        hit_now, fwd, bwd;

  assign fwd     = FACING_RIGHT ? right_i : left_i;
  assign bwd     = FACING_RIGHT ? left_i  : right_i;
  // A hit arriving on the tick cycle itself counts for that tick.
  assign hit_now = pend_q | hit_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | hit_i;
    if (frame_tick_i) begin
      pend_d = 1'b0;
      if (hit_now && state_q == S_BLOCK) begin
        state_d = S_BLOCK;
      end else if (hit_now && state_q != S_GOTHIT) begin
        state_d = S_GOTHIT;
        cnt_d   = TH;
      end else if (is_busy(state_q)) begin
        if (cnt_q == 4'd1) begin
          unique case (state_q)
            S_ATT_START:  begin state_d = S_ATT_END;   cnt_d = TE;   end
            S_ATT_END:    begin state_d = S_ATT_PULL;  cnt_d = TP;   end
            S_DATT_START: begin state_d = S_DATT_END;  cnt_d = TE;   end
            S_DATT_END:   begin state_d = S_DATT_PULL; cnt_d = TP;   end
            default:      begin state_d = S_IDLE;      cnt_d = 4'd0; end
          endcase
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end else if (att_i) begin
        state_d = S_ATT_START;
        cnt_d   = TS;
      end else if (datt_i) begin
        state_d = S_DATT_START;
        cnt_d   = TS;
      end else if (blk_i) begin
        state_d = S_BLOCK;
      end else if (fwd && !bwd) begin
        state_d = S_WALK;
      end else if (bwd && !fwd) begin
        state_d = S_WALKBACK;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      pend_q       <= 1'b0;
      hit_active_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      hit_active_q <= is_hit_active(state_d);
      busy_q       <= is_busy(state_d);
    end
  end

  assign state_o      = state_q;
  assign hit_active_o = hit_active_q;
  assign busy_o       = busy_q;

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Two independent fighter animation FSMs; P1 faces right, P2 faces left.
// Outputs are registered, frame-aligned, one cycle after frame_tick.
module sprite_anim_sequencer
  import anim_pkg::*;
#(
  parameter int T_START = 4,
  parameter int T_END   = 3,
  parameter int T_PULL  = 4,
  parameter int T_HIT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  sprite_anim_if.slave bus
);

  player_anim_fsm #(
    .T_START(T_START), .T_END(T_END), .T_PULL(T_PULL), .T_HIT(T_HIT),
    .FACING_RIGHT(FACE_RIGHT)
  ) u_p1 (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (bus.frame_tick),
    .left_i       (bus.btn_left),
    .right_i      (bus.btn_right),
    .att_i        (bus.btn_att),
    .datt_i       (bus.btn_datt),
    .blk_i        (bus.btn_blk),
    .hit_i        (bus.hit_in),
    .state_o      (bus.currentstate),
    .hit_active_o (bus.hit_active),
    .busy_o       (bus.busy)
  );

  player_anim_fsm #(
    .T_START(T_START), .T_END(T_END), .T_PULL(T_PULL), .T_HIT(T_HIT),
    .FACING_RIGHT(FACE_LEFT)
  ) u_p2 (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (bus.frame_tick),
    .left_i       (bus.btn2_left),
    .right_i      (bus.btn2_right),
    .att_i        (bus.btn2_att),
    .datt_i       (bus.btn2_datt),
    .blk_i        (bus.btn2_blk),
    .hit_i        (bus.hit2_in),
    .state_o      (bus.currentstate2),
    .hit_active_o (bus.hit_active2),
    .busy_o       (bus.busy2)
  );

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Directed bench for sprite_anim_sequencer with default phase durations.
module tb_sprite_anim_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_anim_if bus();

  sprite_anim_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int att_seq[12] = '{3, 3, 3, 3, 4, 4, 4, 5, 5, 5, 5, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_btns();
    bus.btn_left  = 0; bus.btn_right  = 0; bus.btn_att  = 0; bus.btn_datt  = 0; bus.btn_blk  = 0;
    bus.btn2_left = 0; bus.btn2_right = 0; bus.btn2_att = 0; bus.btn2_datt = 0; bus.btn2_blk = 0;
    bus.hit_in = 0; bus.hit2_in = 0;
  endtask

  task automatic tick(input logic h1, input logic h2);
    @(negedge clk);
    bus.frame_tick = 1; bus.hit_in = h1; bus.hit2_in = h2;
    @(negedge clk);
    bus.frame_tick = 0; bus.hit_in = 0; bus.hit2_in = 0;
  endtask

  task automatic pulse_hit(input logic h1, input logic h2);
    @(negedge clk);
    bus.hit_in = h1; bus.hit2_in = h2;
    @(negedge clk);
    bus.hit_in = 0; bus.hit2_in = 0;
  endtask

  task automatic exp_p1(input string tag, input int st);
    check({tag, " st1"}, 32'(bus.currentstate), 32'(st));
    check({tag, " ha1"}, 32'(bus.hit_active), 32'(st == 4 || st == 10));
    check({tag, " busy1"}, 32'(bus.busy), 32'(st inside {3, 4, 5, 7, 8, 9, 10}));
  endtask

  task automatic exp_p2(input string tag, input int st);
    check({tag, " st2"}, 32'(bus.currentstate2), 32'(st));
    check({tag, " ha2"}, 32'(bus.hit_active2), 32'(st == 4 || st == 10));
    check({tag, " busy2"}, 32'(bus.busy2), 32'(st inside {3, 4, 5, 7, 8, 9, 10}));
  endtask

  initial begin
    clear_btns();
    bus.frame_tick = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    exp_p1("reset", 0);
    exp_p2("reset", 0);
    rst = 0;

    // Full attack, button held throughout the busy period and released before the last tick.
    bus.btn_att = 1;
    for (int k = 0; k < 12; k++) begin
      if (k == 11) bus.btn_att = 0;
      tick(0, 0);
      exp_p1($sformatf("att k%0d", k), att_seq[k]);
      exp_p2($sformatf("att p2 k%0d", k), 0);
    end

    // Asynchronous reset in ATT_END.
    bus.btn_att = 1;
    tick(0, 0);
    bus.btn_att = 0;
    repeat (4) tick(0, 0);
    exp_p1("pre-rst", 4);
    @(negedge clk);
    rst = 1;
    #1;
    exp_p1("async rst", 0);
    @(negedge clk);
    rst = 0;
    tick(0, 0);
    exp_p1("post-rst t1", 0);
    tick(0, 0);
    exp_p1("post-rst t2", 0);

    // P2 struck mid-frame during ATT_START.
    bus.btn2_att = 1;
    tick(0, 0);
    bus.btn2_att = 0;
    exp_p2("p2 att", 3);
    tick(0, 0);
    pulse_hit(0, 1);
    repeat (2) @(negedge clk);
    exp_p2("p2 mid-frame", 3);
    for (int k = 0; k < 9; k++) begin
      tick(0, 0);
      exp_p2($sformatf("p2 stun k%0d", k), (k < 8) ? 7 : 0);
    end

    // Block absorbs hits, both mid-frame and coincident with the tick.
    bus.btn_blk = 1;
    tick(0, 0);
    exp_p1("blk", 6);
    pulse_hit(1, 0);
    tick(0, 0);
    exp_p1("blk hit mid", 6);
    tick(1, 0);
    exp_p1("blk hit tick", 6);
    bus.btn_blk = 0;
    tick(0, 0);
    exp_p1("blk rel", 0);

    // Facing: forward is right for P1, left for P2.
    bus.btn_right = 1; bus.btn2_left = 1;
    tick(0, 0);
    check("walk fwd st1", 32'(bus.currentstate), 32'd1);
    check("walk fwd st2", 32'(bus.currentstate2), 32'd1);
    clear_btns();
    bus.btn_left = 1; bus.btn2_right = 1;
    tick(0, 0);
    check("walk back st1", 32'(bus.currentstate), 32'd2);
    check("walk back st2", 32'(bus.currentstate2), 32'd2);
    bus.btn_right = 1; bus.btn2_left = 1;
    tick(0, 0);
    check("walk both st1", 32'(bus.currentstate), 32'd0);
    check("walk both st2", 32'(bus.currentstate2), 32'd0);
    clear_btns();

    // Hit on the tick cycle while walking, then a second hit during the stun.
    bus.btn_right = 1;
    tick(0, 0);
    exp_p1("walk", 1);
    @(negedge clk);
    bus.frame_tick = 1; bus.hit_in = 1;
    @(posedge clk);
    #1;
    exp_p1("hit on tick", 7);
    @(negedge clk);
    bus.frame_tick = 0; bus.hit_in = 0; bus.btn_right = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) pulse_hit(1, 0);
      tick(0, 0);
      exp_p1($sformatf("stun k%0d", k), (k < 8) ? 7 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
